// File: rtl/mpu_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mpu_spi_responder
// Description : SPI mode-3 slave emulating the MPU6500 register interface.
//               It oversamples the SPI pins in the sys_clk domain and holds a
//               128-byte register file. A user-side port can refresh registers
//               at any time.
//               Optional build macro: MPU_SPI_BURST_AUTOINC_EN. When it is
//               defined, bursts auto-increment the address. When it is not
//               defined, extra bytes in a frame are drained and ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module mpu_spi_responder #(
   parameter logic [6:0] WHO_AM_I_ADDR = 7'h75,
   parameter logic [7:0] WHO_AM_I_VAL  = 8'h70,
   parameter logic [6:0] PWR_RST_ADDR  = 7'h6B,
   parameter logic [7:0] PWR_RST_VAL   = 8'h01
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       spi_csn,
   input  logic       spi_clk,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       spi_miso_oe,
   output logic       reg_wr_en,
   output logic [6:0] reg_wr_addr,
   output logic [7:0] reg_wr_data,
   input  logic       upd_en,
   input  logic [6:0] upd_addr,
   input  logic [7:0] upd_data,
   output logic       upd_ack,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CMD   = 2'd1,
      ST_DATA  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Synchronisers: stages [1:0] resynchronise the pin, stage [2] is the edge-detect history
   logic [2:0] csn_q;
   logic [2:0] sck_q;
   logic [1:0] mosi_q;

   logic       csn_fall;
   logic       csn_rise;
   logic       sck_fall;
   logic       sck_rise;
   logic       mosi_s;

   state_t     state_q;
   logic [2:0] bit_cnt_q;
   logic [6:0] shift_in_q;
   logic       rw_q;
   logic [6:0] addr_q;
   logic [7:0] tx_shift_q;
   logic       miso_q;
   logic       miso_oe_q;
   logic       busy_q;
   logic       reg_wr_en_q;
   logic [6:0] reg_wr_addr_q;
   logic [7:0] reg_wr_data_q;
   logic       upd_ack_q;
   logic [7:0] regs_q [128];

   assign csn_fall = ~csn_q[1] &  csn_q[2];
   assign csn_rise =  csn_q[1] & ~csn_q[2];
   assign sck_fall = ~sck_q[1] &  sck_q[2];
   assign sck_rise =  sck_q[1] & ~sck_q[2];
   assign mosi_s   =  mosi_q[1];

   // Value presented to the master for a read; the identity register is hard-wired
   function automatic logic [7:0] rd_val(input logic [6:0] a);
      rd_val = (a == WHO_AM_I_ADDR) ? WHO_AM_I_VAL : regs_q[a];
   endfunction

   // Bring the asynchronous SPI pins into the sys_clk domain
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         csn_q  <= 3'b111;
         sck_q  <= 3'b111;
         mosi_q <= 2'b00;
      end else begin
         csn_q  <= {csn_q[1:0], spi_csn};
         sck_q  <= {sck_q[1:0], spi_clk};
         mosi_q <= {mosi_q[0], spi_mosi};
      end
   end

   // Frame sequencer: command byte, data byte(s), write commit and MISO driving
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         bit_cnt_q     <= 3'd0;
         shift_in_q    <= 7'd0;
         rw_q          <= 1'b0;
         addr_q        <= 7'd0;
         tx_shift_q    <= 8'd0;
         miso_q        <= 1'b0;
         miso_oe_q     <= 1'b0;
         busy_q        <= 1'b0;
         reg_wr_en_q   <= 1'b0;
         reg_wr_addr_q <= 7'd0;
         reg_wr_data_q <= 8'd0;
      end else begin
         reg_wr_en_q <= 1'b0;
         if (csn_rise) begin
            // CS release aborts whatever is in flight; a partial byte never commits
            state_q   <= ST_IDLE;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (csn_fall) begin
                     bit_cnt_q <= 3'd0;
                     busy_q    <= 1'b1;
                     state_q   <= ST_CMD;
                  end
               end
               ST_CMD: begin
                  if (sck_rise) begin
                     shift_in_q <= {shift_in_q[5:0], mosi_s};
                     bit_cnt_q  <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        rw_q       <= shift_in_q[6];
                        addr_q     <= {shift_in_q[5:0], mosi_s};
                        tx_shift_q <= rd_val({shift_in_q[5:0], mosi_s});
                        miso_oe_q  <= shift_in_q[6];
                        state_q    <= ST_DATA;
                     end
                  end
               end
               ST_DATA: begin
                  if (sck_fall && rw_q) begin
                     miso_q     <= tx_shift_q[7];
                     tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                  end
                  if (sck_rise) begin
                     shift_in_q <= {shift_in_q[5:0], mosi_s};
                     bit_cnt_q  <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        if (!rw_q) begin
                           reg_wr_en_q   <= 1'b1;
                           reg_wr_addr_q <= addr_q;
                           reg_wr_data_q <= {shift_in_q, mosi_s};
                        end
`ifdef MPU_SPI_BURST_AUTOINC_EN
                        addr_q <= addr_q + 7'd1;
                        if (rw_q) begin
                           tx_shift_q <= rd_val(addr_q + 7'd1);
                        end
`else
                        state_q   <= ST_DRAIN;
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
`endif
                     end
                  end
               end
               ST_DRAIN: begin
                  // Extra bytes are ignored until chip select is released
                  state_q <= ST_DRAIN;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Register file: an SPI commit takes priority, and a colliding user update waits one cycle
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 128; i++) begin
            regs_q[i] <= (7'(i) == PWR_RST_ADDR) ? PWR_RST_VAL : 8'h00;
         end
         upd_ack_q <= 1'b0;
      end else begin
         upd_ack_q <= 1'b0;
         if (reg_wr_en_q) begin
            if (reg_wr_addr_q != WHO_AM_I_ADDR) begin
               regs_q[reg_wr_addr_q] <= reg_wr_data_q;
            end
         end else if (upd_en && !upd_ack_q) begin
            if (upd_addr != WHO_AM_I_ADDR) begin
               regs_q[upd_addr] <= upd_data;
            end
            upd_ack_q <= 1'b1;
         end
      end
   end

   assign spi_miso    = miso_q & miso_oe_q;
   assign spi_miso_oe = miso_oe_q;
   assign reg_wr_en   = reg_wr_en_q;
   assign reg_wr_addr = reg_wr_addr_q;
   assign reg_wr_data = reg_wr_data_q;
   assign upd_ack     = upd_ack_q;
   assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mpu_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mpu_spi_responder
// Description : Self-checking bench for mpu_spi_responder. An SPI mode-3
//               master runs at sys_clk/8. A plain array register model
//               provides all expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mpu_spi_responder;

   localparam int H = 4;   // sys_clk cycles per SPI half period

   logic       sys_clk     = 1'b0;
   logic       rst         = 1'b1;
   logic       spi_csn     = 1'b1;
   logic       spi_clk     = 1'b1;
   logic       spi_mosi    = 1'b0;
   logic       spi_miso;
   logic       spi_miso_oe;
   logic       reg_wr_en;
   logic [6:0] reg_wr_addr;
   logic [7:0] reg_wr_data;
   logic       upd_en      = 1'b0;
   logic [6:0] upd_addr    = 7'd0;
   logic [7:0] upd_data    = 8'd0;
   logic       upd_ack;
   logic       busy;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  mem [128];
   logic [7:0]  mtx [4];
   logic [7:0]  mrx [4];
   logic [31:0] oe_bits;
   logic        busy_mid;
   logic [14:0] wrq [$];

   always #5 sys_clk = ~sys_clk;

   mpu_spi_responder dut (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .spi_csn     (spi_csn),
      .spi_clk     (spi_clk),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .reg_wr_en   (reg_wr_en),
      .reg_wr_addr (reg_wr_addr),
      .reg_wr_data (reg_wr_data),
      .upd_en      (upd_en),
      .upd_addr    (upd_addr),
      .upd_data    (upd_data),
      .upd_ack     (upd_ack),
      .busy        (busy)
   );

   // Log every write-commit pulse
   always @(negedge sys_clk) begin
      if (reg_wr_en === 1'b1) wrq.push_back({reg_wr_addr, reg_wr_data});
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] model_read(input logic [6:0] a);
      return (a == 7'h75) ? 8'h70 : mem[a];
   endfunction

   task automatic model_write(input logic [6:0] a, input logic [7:0] d);
      if (a != 7'h75) mem[a] = d;
   endtask

   // ---------------- SPI master (mode 3, MSB first) ----------------
   task automatic spi_frame(input int nbits);
      int byt;
      int bp;
      oe_bits  = '0;
      busy_mid = 1'b0;
      for (int i = 0; i < 4; i++) mrx[i] = 8'h00;
      @(negedge sys_clk);
      spi_csn = 1'b0;
      repeat (H) @(negedge sys_clk);
      for (int b = 0; b < nbits; b++) begin
         byt = b / 8;
         bp  = 7 - (b % 8);
         spi_clk  = 1'b0;
         spi_mosi = mtx[byt][bp];
         repeat (H) @(negedge sys_clk);
         mrx[byt][bp] = spi_miso;
         oe_bits[b]   = spi_miso_oe;
         if (b == 4) busy_mid = busy;
         spi_clk = 1'b1;
         repeat (H) @(negedge sys_clk);
      end
      spi_csn  = 1'b1;
      spi_mosi = 1'b0;
      repeat (H + 2) @(negedge sys_clk);
   endtask

   task automatic do_read(input logic [6:0] a);
      mtx[0] = {1'b1, a};
      mtx[1] = 8'($urandom);
      spi_frame(16);
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] d);
      mtx[0] = {1'b0, a};
      mtx[1] = d;
      wrq.delete();
      spi_frame(16);
      model_write(a, d);
   endtask

   task automatic do_update(input logic [6:0] a, input logic [7:0] d, output int lat);
      upd_addr = a;
      upd_data = d;
      upd_en   = 1'b1;
      lat      = 0;
      do begin
         @(negedge sys_clk);
         lat++;
      end while (upd_ack !== 1'b1 && lat < 20);
      upd_en = 1'b0;
      model_write(a, d);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++;
      if ({spi_miso, spi_miso_oe, reg_wr_en, upd_ack, busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got miso/oe/wr/ack/busy=%b want 00000",
                  {spi_miso, spi_miso_oe, reg_wr_en, upd_ack, busy});
      end
      checks++;
      if ({reg_wr_addr, reg_wr_data} !== 15'd0) begin
         errors++;
         $display("FAIL reset_wr_bus: got addr=%h data=%h want 00/00", reg_wr_addr, reg_wr_data);
      end
   endtask

   task automatic test_whoami();
      do_read(7'h75);
      checks++;
      if (mrx[1] !== 8'h70) begin
         errors++;
         $display("FAIL whoami_read: got %h want 70", mrx[1]);
      end
      checks++;
      if (oe_bits[15:0] !== 16'hFF00) begin
         errors++;
         $display("FAIL whoami_oe: got %h want ff00", oe_bits[15:0]);
      end
      checks++;
      if (busy_mid !== 1'b1 || busy !== 1'b0 || spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin
         errors++;
         $display("FAIL whoami_busy: got mid=%b after=%b oe=%b miso=%b want 1 0 0 0",
                  busy_mid, busy, spi_miso_oe, spi_miso);
      end
      do_read(7'h6B);
      checks++;
      if (mrx[1] !== 8'h01) begin
         errors++;
         $display("FAIL pwr_rst_read: got %h want 01", mrx[1]);
      end
   endtask

   task automatic test_write_read();
      do_write(7'h1B, 8'h18);
      checks++;
      if (wrq.size() != 1 || wrq[0] !== {7'h1B, 8'h18}) begin
         errors++;
         $display("FAIL write_pulse_1b: got n=%0d first=%h want n=1 %h", wrq.size(), wrq[0], {7'h1B, 8'h18});
      end
      do_read(7'h1B);
      checks++;
      if (mrx[1] !== model_read(7'h1B)) begin
         errors++;
         $display("FAIL readback_1b: got %h want %h", mrx[1], model_read(7'h1B));
      end
      do_write(7'h75, 8'hFF);
      checks++;
      if (wrq.size() != 1 || wrq[0] !== {7'h75, 8'hFF}) begin
         errors++;
         $display("FAIL write_pulse_75: got n=%0d first=%h want n=1 %h", wrq.size(), wrq[0], {7'h75, 8'hFF});
      end
      do_read(7'h75);
      checks++;
      if (mrx[1] !== 8'h70) begin
         errors++;
         $display("FAIL readback_75: got %h want 70", mrx[1]);
      end
   endtask

   task automatic test_abort();
      mtx[0] = {1'b0, 7'h20};
      mtx[1] = 8'h5A | 8'($urandom);
      wrq.delete();
      spi_frame(11);
      checks++;
      if (wrq.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_nowrite: got pulses=%0d busy=%b want 0 0", wrq.size(), busy);
      end
      do_read(7'h20);
      checks++;
      if (mrx[1] !== model_read(7'h20)) begin
         errors++;
         $display("FAIL abort_readback: got %h want %h", mrx[1], model_read(7'h20));
      end
   endtask

   task automatic test_update();
      int          lat;
      int          n;
      logic [7:0]  wd;
      logic [7:0]  ud;
      do_update(7'h3B, 8'hA5, lat);
      checks++;
      if (lat != 1) begin
         errors++;
         $display("FAIL upd_idle_latency: got %0d want 1", lat);
      end
      @(negedge sys_clk);
      checks++;
      if (upd_ack !== 1'b0) begin
         errors++;
         $display("FAIL upd_ack_pulse: got %b want 0", upd_ack);
      end
      do_read(7'h3B);
      checks++;
      if (mrx[1] !== 8'hA5) begin
         errors++;
         $display("FAIL upd_readback_3b: got %h want a5", mrx[1]);
      end
      // update lands exactly in the SPI commit cycle
      wd = 8'($urandom);
      ud = 8'($urandom);
      mtx[0] = {1'b0, 7'h3C};
      mtx[1] = wd;
      wrq.delete();
      lat = 0;
      n   = 0;
      fork
         spi_frame(16);
         begin
            while (reg_wr_en !== 1'b1 && n < 400) begin
               @(negedge sys_clk);
               n++;
            end
            do_update(7'h3D, ud, lat);
         end
      join
      model_write(7'h3C, wd);
      checks++;
      if (n >= 400 || lat != 2) begin
         errors++;
         $display("FAIL upd_contended_latency: got %0d (wait %0d) want 2", lat, n);
      end
      checks++;
      if (wrq.size() != 1 || wrq[0] !== {7'h3C, wd}) begin
         errors++;
         $display("FAIL contended_write_pulse: got n=%0d first=%h want n=1 %h", wrq.size(), wrq[0], {7'h3C, wd});
      end
      do_read(7'h3C);
      checks++;
      if (mrx[1] !== model_read(7'h3C)) begin
         errors++;
         $display("FAIL contended_readback_3c: got %h want %h", mrx[1], model_read(7'h3C));
      end
      do_read(7'h3D);
      checks++;
      if (mrx[1] !== model_read(7'h3D)) begin
         errors++;
         $display("FAIL contended_readback_3d: got %h want %h", mrx[1], model_read(7'h3D));
      end
   endtask

   task automatic test_burst();
      int         lat;
      logic [7:0] e1;
      logic [7:0] e2;
      logic [7:0] e3;
      logic [7:0] a;
      logic [7:0] b;
      do_write(7'h7E, 8'h11);
      do_write(7'h7F, 8'h22);
      do_update(7'h00, 8'h33, lat);
      mtx[0] = {1'b1, 7'h7E};
      mtx[1] = 8'($urandom);
      mtx[2] = 8'($urandom);
      mtx[3] = 8'($urandom);
      spi_frame(32);
`ifdef MPU_SPI_BURST_AUTOINC_EN
      e1 = model_read(7'h7E);
      e2 = model_read(7'h7F);
      e3 = model_read(7'h00);
      checks++;
      if (oe_bits !== 32'hFFFFFF00) begin
         errors++;
         $display("FAIL burst_read_oe: got %h want ffffff00", oe_bits);
      end
`else
      e1 = model_read(7'h7E);
      e2 = 8'h00;
      e3 = 8'h00;
      checks++;
      if (oe_bits !== 32'h0000FF00) begin
         errors++;
         $display("FAIL burst_read_oe: got %h want 0000ff00", oe_bits);
      end
`endif
      checks++;
      if ({mrx[1], mrx[2], mrx[3]} !== {e1, e2, e3}) begin
         errors++;
         $display("FAIL burst_read_data: got %h %h %h want %h %h %h", mrx[1], mrx[2], mrx[3], e1, e2, e3);
      end
      a = 8'($urandom);
      b = 8'($urandom);
      mtx[0] = {1'b0, 7'h7F};
      mtx[1] = a;
      mtx[2] = b;
      wrq.delete();
      spi_frame(24);
      model_write(7'h7F, a);
`ifdef MPU_SPI_BURST_AUTOINC_EN
      model_write(7'h00, b);
      checks++;
      if (wrq.size() != 2 || wrq[0] !== {7'h7F, a} || wrq[1] !== {7'h00, b}) begin
         errors++;
         $display("FAIL burst_write_pulses: got n=%0d want 2 (%h,%h)", wrq.size(), {7'h7F, a}, {7'h00, b});
      end
`else
      checks++;
      if (wrq.size() != 1 || wrq[0] !== {7'h7F, a}) begin
         errors++;
         $display("FAIL burst_write_pulses: got n=%0d want 1 (%h)", wrq.size(), {7'h7F, a});
      end
`endif
      do_read(7'h00);
      checks++;
      if (mrx[1] !== model_read(7'h00)) begin
         errors++;
         $display("FAIL burst_readback_00: got %h want %h", mrx[1], model_read(7'h00));
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] a;
      logic [7:0] d;
      logic       rd;
      for (int f = 0; f < 16; f++) begin
         rd = 1'($urandom_range(0, 1));
         a  = 7'h10 + 7'($urandom_range(0, 3));
         d  = 8'($urandom);
         if (f == 5) a = 7'h75;
         if (f < 2) rd = 1'b0;
         mtx[0] = {rd, a};
         mtx[1] = d;
         wrq.delete();
         spi_frame(16);
         checks++;
         if (rd) begin
            if (mrx[1] !== model_read(a) || oe_bits[15:0] !== 16'hFF00) begin
               errors++;
               $display("FAIL b2b_read frame %0d addr %h: got %h oe=%h want %h oe=ff00",
                        f, a, mrx[1], oe_bits[15:0], model_read(a));
            end
         end else begin
            if (wrq.size() != 1 || wrq[0] !== {a, d}) begin
               errors++;
               $display("FAIL b2b_write frame %0d: got n=%0d first=%h want n=1 %h",
                        f, wrq.size(), wrq[0], {a, d});
            end
            model_write(a, d);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = (i == 'h6B) ? 8'h01 : 8'h00;
      repeat (3) @(negedge sys_clk);
      rst = 1'b0;
      @(negedge sys_clk);
      test_reset();
      test_whoami();
      test_write_read();
      test_abort();
      test_update();
      test_burst();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mpu_spi_responder.md
Name: mpu_spi_responder

Overview:
- SPI slave that emulates the MPU6500 register interface, in the sys_clk domain.
- Serves as the bench and loopback counterpart for the team's SPI configuration master: it answers register reads, accepts register writes and holds a 128-byte register file.
- A user-side update port lets sensor-sample logic refresh data registers while the bus is idle or busy.
- SPI clock and data are oversampled; sys_clk must be at least 8x spi_clk.

Parameters:
- WHO_AM_I_ADDR, 7'h75, address of the read-only identity register.
- WHO_AM_I_VAL, 8'h70, value returned at WHO_AM_I_ADDR; writes to it are ignored.
- PWR_RST_ADDR, 7'h6B, address whose reset value differs from zero.
- PWR_RST_VAL, 8'h01, reset value of PWR_RST_ADDR.

Ports:
- sys_clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- spi_csn  in  1  chip select, active low, asynchronous to sys_clk.
- spi_clk  in  1  SPI clock, mode 3 (CPOL=1, CPHA=1), asynchronous to sys_clk.
- spi_mosi  in  1  serial data from the master, MSB first.
- spi_miso  out  1  serial data to the master.
- spi_miso_oe  out  1  output enable for spi_miso; high only during the data byte of a read.
- reg_wr_en  out  1  one-cycle pulse when an SPI write commits.
- reg_wr_addr  out  7  address of the committed write.
- reg_wr_data  out  8  data of the committed write.
- upd_en  in  1  user-side register update request.
- upd_addr  in  7  user-side update address.
- upd_data  in  8  user-side update data.
- upd_ack  out  1  one-cycle pulse when the user-side update is applied.
- busy  out  1  high from chip-select assertion until deassertion.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, reg_wr_en=0, reg_wr_addr=0, reg_wr_data=0, upd_ack=0, busy=0, FSM=IDLE. Register file is all 0x00 except PWR_RST_ADDR=PWR_RST_VAL.
- Input synchronisation: spi_csn, spi_clk and spi_mosi each pass through 2 flip-flops. Edge detect uses a third stage. Rise and fall strobes are therefore valid 3 sys_clk cycles after the pin edge.
- Frame format: 16 bits.
  - bit15 = R/W (1 = read).
  - bits14:8 = address.
  - bits7:0 = data.
  - mosi is sampled on each spi_clk rise strobe; miso is updated on each fall strobe.
- FSM states and transitions:
  - IDLE: a csn falling edge (synchronised) clears the bit counter, sets busy=1 and moves to CMD.
  - CMD: shift in 8 bits. On the 8th rise, latch rw and addr. For a read, load tx_shift from the register file at addr (WHO_AM_I_ADDR returns WHO_AM_I_VAL). Then move to DATA.
  - DATA, read: spi_miso_oe=1. spi_miso=tx_shift[7] is driven on the first fall strobe after the 8th rise, then shifts on every fall strobe. Write bits are shifted in on rise strobes.
  - DATA, byte complete (8th rise of the data byte), write: on the next cycle, update regs[addr] unless addr==WHO_AM_I_ADDR, and pulse reg_wr_en with addr and data. The pulse occurs even for the WHO_AM_I address; the register itself is unchanged.
  - DATA, byte complete, read: no register change.
  - After a completed data byte, continuation follows BURST_AUTOINC_EN.
- CS deassert at any point (synchronised rising csn): go to IDLE and drop spi_miso_oe and busy the same cycle. A partial byte is discarded with no write and no reg_wr_en.
- Address arithmetic is 7-bit modulo: 0x7F+1 wraps to 0x00.
- Update port:
  - upd_en is applied in the same cycle if no SPI write commits that cycle, and upd_ack pulses the following cycle.
  - If an SPI commit coincides, the SPI write wins, the update is held and it is applied the next cycle.
  - upd_en must stay asserted until upd_ack.
  - Updates to WHO_AM_I_ADDR are acked but ignored.
- A read returns the register value at the moment of the 8th address-bit rise; later updates do not alter bits already being shifted.
- spi_miso is 0 whenever spi_miso_oe=0.

Optional Feature:
- Macro: MPU_SPI_BURST_AUTOINC_EN.
- Defined: after each completed data byte with CS still low, the address increments (7-bit wrap). A read reloads tx_shift from the new address for the next fall strobe, and a write commits each further byte to successive addresses.
- Undefined: after the first data byte the FSM enters a DRAIN state until CS rises. In DRAIN, spi_miso_oe=0, incoming bits are ignored and no writes commit.

Test Plan:
- Reset, then read 0x75 -> miso byte 0x70, spi_miso_oe high only for the 8 data bits; read 0x6B -> 0x01.
- Write 0x1B=0x18, then read 0x1B -> reg_wr_en pulses once with addr 0x1B and data 0x18; readback 0x18. Write 0x75=0xFF -> reg_wr_en pulses, readback remains 0x70.
- CS raised after 11 bits of a write to 0x20 -> no reg_wr_en, busy falls, register 0x20 stays 0x00.
- upd_en at 0x3B=0xA5 during an idle bus -> upd_ack one cycle later. upd_en coincident with an SPI write commit to 0x3C -> SPI write applied first, upd_ack one cycle later than the uncontended case, both values read back.
- With MPU_SPI_BURST_AUTOINC_EN: after preloading 0x7E=0x11, 0x7F=0x22, 0x00=0x33, a burst read from 0x7E for 3 bytes -> 0x11, 0x22, 0x33 (wrap). Without the macro: second byte reads 0 with spi_miso_oe low.
- Minimum ratio: spi_clk = sys_clk/8 over 16 back-to-back frames -> no bit errors.
